// File: rtl/uart_rx_core.sv
// uart_rx_core: receive side of the UART link.
// The serial line is oversampled at Prescale clocks per bit, and three samples
// around the centre of each bit are majority-voted. The block checks the start
// bit for glitches, then checks the optional parity bit and the stop bit.
// The received word is presented with a one-cycle valid strobe. Error strobes
// are raised instead of the valid strobe when a check fails.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err,
  output logic                  busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [PRESC_W-1:0] EC_ONE   = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] EC_ZERO  = PRESC_W'(0);
  localparam logic [BCW-1:0]     BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]     BIT_ONE  = BCW'(1);
  localparam logic [BCW-1:0]     BIT_ZERO = BCW'(0);

  // Majority of three samples; a single-cycle line glitch cannot flip the bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit: even parity is the XOR of the data, odd parity is its inverse.
  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~(^d) : (^d);
  endfunction

  logic                  sync1_r;
  logic                  rx_sync_r;
  logic                  rx_s;
  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [PRESC_W-1:0]    edge_cnt_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic [PRESC_W-1:0]    presc_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [2:0]            smp_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_mis_r;

  logic [PRESC_W-1:0]    half_s;
  logic                  last_edge_s;
  logic                  vote_s;
  logic                  start_det_s;
  logic                  stop_done_s;
  logic                  par_bad_s;
  logic                  stp_bad_s;

  assign rx_s = rx_sync_r;

  // Decode the bit-timing points and the voted bit from the latched frame configuration.
  always_comb begin
    half_s      = {1'b0, presc_r[PRESC_W-1:1]};
    last_edge_s = (edge_cnt_r == (presc_r - EC_ONE));
    vote_s      = majority3(smp_r[0], smp_r[1], smp_r[2]);
    start_det_s = (state_r == ST_IDLE) && !rx_s;
    stop_done_s = (state_r == ST_STOP) && last_edge_s;
    par_bad_s   = par_en_r & par_mis_r;
    stp_bad_s   = ~vote_s;
  end

  // Frame sequencing: start check, data bits, optional parity, then the stop bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) state_nxt_s = ST_START;
        else       state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (last_edge_s) begin
          if (vote_s) state_nxt_s = ST_IDLE;
          else        state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (last_edge_s && (bit_cnt_r == BIT_LAST)) begin
          if (par_en_r) state_nxt_s = ST_PARITY;
          else          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (last_edge_s) state_nxt_s = ST_STOP;
        else             state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (last_edge_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Two-flop synchronizer for the asynchronous serial line; it resets to the idle level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_r   <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      sync1_r   <= RX_IN;
      rx_sync_r <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Per-bit oversampling counter; it is held at zero while idle so START begins at edge 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_r <= EC_ZERO;
    end else if (state_r == ST_IDLE) begin
      edge_cnt_r <= EC_ZERO;
    end else if (last_edge_s) begin
      edge_cnt_r <= EC_ZERO;
    end else begin
      edge_cnt_r <= edge_cnt_r + EC_ONE;
    end
  end

  // Capture the frame configuration at start detection, so that input changes mid-frame are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_r   <= PRESC_W'(8);
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else if (start_det_s) begin
      presc_r   <= Prescale;
      par_en_r  <= PAR_EN;
      par_typ_r <= PAR_TYP;
    end
  end

  // Take three consecutive samples around the middle of each bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_r <= 3'b111;
    end else if (state_r != ST_IDLE) begin
      if (edge_cnt_r == (half_s - EC_ONE)) smp_r[0] <= rx_s;
      if (edge_cnt_r == half_s)            smp_r[1] <= rx_s;
      if (edge_cnt_r == (half_s + EC_ONE)) smp_r[2] <= rx_s;
    end
  end

  // Shift data bits in LSB first at the end of each data bit, and count them.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_r <= BIT_ZERO;
      shift_r   <= {DATA_WIDTH{1'b0}};
    end else if (state_r == ST_START) begin
      bit_cnt_r <= BIT_ZERO;
    end else if ((state_r == ST_DATA) && last_edge_s) begin
      shift_r   <= {vote_s, shift_r[DATA_WIDTH-1:1]};
      bit_cnt_r <= bit_cnt_r + BIT_ONE;
    end
  end

  // Store the parity mismatch flag at the end of the parity bit; it is cleared for each new frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_mis_r <= 1'b0;
    end else if (state_r == ST_START) begin
      par_mis_r <= 1'b0;
    end else if ((state_r == ST_PARITY) && last_edge_s) begin
      par_mis_r <= vote_s ^ frame_parity(shift_r, par_typ_r);
    end
  end

  // Register the frame result and strobes. P_DATA is updated only by a clean frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= {DATA_WIDTH{1'b0}};
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= (state_nxt_s != ST_IDLE);
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      if (stop_done_s) begin
        Stp_Err <= stp_bad_s;
        Par_Err <= par_bad_s;
        if (!stp_bad_s && !par_bad_s) begin
          Data_Valid <= 1'b1;
          P_DATA     <= shift_r;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Receive-side UART block: the counterpart of the existing transmit FSM/serializer path.
- Oversamples the serial line at Prescale clocks per bit and majority-votes three centre samples per bit.
- Checks start glitch, optional parity and stop bit, then presents the deserialized word with a one-cycle valid strobe and error strobes.
- Frame format matches TX: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESC_W, 6, width of Prescale input

Ports:
CLK  input  1  clock
RST  input  1  asynchronous reset, active-low
RX_IN  input  1  serial line, idle high, asynchronous to CLK
PAR_EN  input  1  1 = frame carries parity bit
PAR_TYP  input  1  0 = even, 1 = odd parity
Prescale  input  PRESC_W  clocks per bit; legal values 8, 16, 32
P_DATA  output  DATA_WIDTH  received word
Data_Valid  output  1  one-cycle strobe, P_DATA valid
Par_Err  output  1  one-cycle strobe, parity mismatch
Stp_Err  output  1  one-cycle strobe, stop bit sampled 0
busy  output  1  frame reception in progress

Behaviour:
- Reset (RST low, async): state IDLE, counters 0, P_DATA=0, Data_Valid=Par_Err=Stp_Err=busy=0. Synchronizer flops reset to 1.
- RX_IN passes a 2-flop synchronizer; all logic below uses the synchronized value rx_s (2-cycle latency).
- Config latch: Prescale, PAR_EN and PAR_TYP are captured on the IDLE->START transition and held for the frame. Other Prescale values are unsupported.
- Edge counter edge_cnt runs 0..Prescale-1 within each bit, then wraps to 0 and advances the bit.
- Bit counter bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: rx_s captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. Bit value = majority of the 3 samples, valid from edge_cnt = Prescale/2+2.
- States:
  - IDLE: busy=0. rx_s=0 -> START, edge_cnt=0 in the first START cycle.
  - START: at edge_cnt=Prescale-1, if the voted bit is 1 (glitch) -> IDLE with no strobes; else -> DATA with bit_cnt=0.
  - DATA: the voted bit is shifted in LSB first (bit 0 first) into an internal shift register. At edge_cnt=Prescale-1 of bit DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: the voted bit is compared with the computed parity, where even = XOR of data and odd = ~XOR. The mismatch flag is stored. At edge_cnt=Prescale-1 -> STOP.
  - STOP: at edge_cnt=Prescale-1 -> IDLE and frame result registered:
    - Stp_Err=1 if the voted stop bit is 0.
    - Par_Err=1 if PAR_EN and mismatch.
    - Data_Valid=1 and P_DATA<=shift register only if neither error.
- Strobes are high for exactly the one cycle after the last STOP edge. P_DATA holds its previous value on error frames and between frames.
- busy=1 in START, DATA, PARITY, STOP. It falls in the same cycle the strobes rise.
- Frame length: Prescale*(DATA_WIDTH+2+PAR_EN) cycles from first START cycle to the strobe cycle.
- Back-to-back frames: a start bit immediately after the stop is detected in IDLE on the next cycle. One cycle of slip per frame is within the half-bit sampling margin.
- Reset mid-frame: immediate return to IDLE, no strobes, partial data discarded.
- Line held low (break): error frame with Stp_Err. The block then re-enters START while rx_s remains 0.

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity 0, stop 1 -> Data_Valid pulse 1 cycle, P_DATA=0xA5, Par_Err=Stp_Err=0, busy high for 88 cycles.
2. Same as 1 but parity bit 1 -> Par_Err pulse, Data_Valid=0, P_DATA stays 0xA5 from the prior frame.
3. Prescale=16, PAR_EN=0, send 0x5A with stop bit 0 -> Stp_Err pulse, Data_Valid=0, Par_Err=0.
4. Prescale=16, RX_IN low for 3 cycles then high -> START aborts to IDLE after 16 cycles, no strobes, busy back to 0.
5. Prescale=32, PAR_EN=0, back-to-back 0x3C then 0xC3 with a 1-cycle inverted glitch on the centre sample of data bit 2 of 0x3C -> two Data_Valid pulses, P_DATA=0x3C then 0xC3.
6. RST low during DATA bit 4 of a frame, release, send 0x81 (PAR_EN=1, PAR_TYP=1, parity 1) -> all outputs 0 during reset, next frame gives Data_Valid, P_DATA=0x81.
